uart_operand_loader: RTL and testbench
======================================

# uart_operand_loader

Receive side of the array's UART link. Deserialises 8N1 UART bytes from the `rx` pin and assembles them into one operand vector: 4 weight bytes for `top_inputs` and 8 activation bytes for `left_inputs`. Each completed vector is presented to the systolic array with a one-cycle `vector_valid` strobe. This block is the receive counterpart of the array's `uart_tx` result path and must use the same bit timing.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Must be even and ≥ 4.
- `clk`, input, 1: sole clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `rx`, input, 1: asynchronous UART line; idles high.
- `top_inputs`, output, 32: weight vector; byte lane k is `[8k+7:8k]`.
- `left_inputs`, output, 64: activation vector; byte lane k is `[8k+7:8k]`.
- `vector_valid`, output, 1: one-cycle pulse when `top_inputs`/`left_inputs` update.
- `byte_out`, output, 8: last byte received with good framing.
- `byte_valid`, output, 1: one-cycle pulse when `byte_out` updates.
- `frame_err`, output, 1: one-cycle pulse on a bad stop bit.
- `vectors_count`, output, 6: completed vectors since reset; wraps 63→0.

## Operation
- **Input sync:** `rx` passes through a 2-flop synchroniser (`rx_s`) before any use. Both flops reset to 1.
- **Bit timing:** H = CLKS_PER_BIT/2. The FSM runs IDLE → START → DATA → STOP → IDLE, plus a BREAK state.
  - IDLE: `rx_s`==0 → START, bit counter cleared.
  - START: after H cycles, sample `rx_s`. 0 → DATA; 1 → IDLE (glitch rejected, no pulse).
  - DATA: every CLKS_PER_BIT cycles, sample one bit into the shift register, LSB first. After 8 bits → STOP.
  - STOP: after CLKS_PER_BIT cycles, sample `rx_s`. 1 → load `byte_out`, pulse `byte_valid`, go to IDLE. 0 → pulse `frame_err`, discard the byte, go to BREAK.
  - BREAK: stay until `rx_s`==1, then IDLE. A held-low line therefore yields exactly one `frame_err`.
- **Vector assembly:** a 4-bit byte index (0..11) steers each good byte into a shadow register.
  - Index 0–3 → `top_inputs` lane 0–3.
  - Index 4–11 → `left_inputs` lane 0–7.
  - On the good byte at index 11: both outputs load from the shadow register together, `vector_valid` pulses, `vectors_count` increments, and the index returns to 0.
  - `top_inputs`/`left_inputs` stay stable between `vector_valid` pulses. The array never sees a partial vector.
- **Framing error:** `frame_err` resets the byte index to 0 and drops the partial vector. Output vectors and `vectors_count` are unchanged.
- **Reset:** applies at any point, including mid-frame or mid-vector. Every output goes to 0 and the FSM goes to IDLE. The byte index, shift register and shadow register clear. No pulse is emitted for the interrupted frame.

## Timing
- Let S be the first cycle IDLE sees `rx_s`==0. This is 2–3 cycles after the `rx` falling edge.
- Start sampled at S+H. Data bit i (0..7) sampled at S+H+(i+1)·CLKS_PER_BIT. Stop sampled at S+H+9·CLKS_PER_BIT.
- `byte_valid`/`frame_err` are high during cycle S+H+9·CLKS_PER_BIT+1. `byte_out` is valid from that cycle onward.
- `vector_valid` is coincident with the `byte_valid` of byte index 11. New vector values are visible in the same cycle.
- Back-to-back frames need no idle gap. The next start edge may begin in the cycle after the stop sample.
- There is no backpressure. The consumer must capture each vector before 12 further byte times elapse.

## Test plan
- **Single byte:** CLKS_PER_BIT=16. Send 0xA5 → `byte_out`=0xA5 and `byte_valid` one cycle high, at 8+9·16+1 cycles after S. `frame_err` stays 0.
- **Full vector:** send bytes 0x01..0x0C back-to-back → `top_inputs`=0x04030201, `left_inputs`=0x0C0B0A0908070605. One `vector_valid` pulse, `vectors_count`=1, outputs unchanged before the 12th byte.
- **Glitch:** pulse `rx` low for 3 cycles → no `byte_valid`, no `frame_err`, FSM back in IDLE.
- **Bad stop bit:** send 5 good bytes, then a frame with stop=0, then 12 good bytes 0x10..0x1B → exactly one `frame_err`, and one `vector_valid` carrying 0x13121110 / 0x1B1A191817161514.
- **Break:** hold `rx` low for 40 bit times → exactly one `frame_err`. A following byte 0x3C is received correctly.
- **Mid-frame reset:** assert `rst` mid-DATA of the 7th byte → all outputs 0 next cycle. A following full 12-byte vector gives `vectors_count`=1.

Source files
------------

// File: rtl/uart_operand_loader.sv
// Purpose: 8N1 UART receiver that assembles 4 weight + 8 activation bytes into one operand vector.
// Latency: byte_valid one cycle after the stop-bit sample; vector_valid coincident with the 12th byte_valid.
// Backpressure: none; the consumer must take each vector before the next one completes.
module uart_operand_loader #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   output logic [31:0] top_inputs,
   output logic [63:0] left_inputs,
   output logic        vector_valid,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   output logic        frame_err,
   output logic [5:0]  vectors_count
);

   localparam int H  = CLKS_PER_BIT / 2;
   localparam int CW = $clog2(CLKS_PER_BIT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t        state;
   logic [CW-1:0] clk_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic [3:0]    byte_idx;
   logic [95:0]   shadow;
   logic          rx_meta;
   logic          rx_s;

   // Two-flop synchroniser; resets to the idle (high) line level.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // Receive FSM, byte steering into the shadow register and vector hand-off.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         clk_cnt       <= '0;
         bit_idx       <= '0;
         shreg         <= '0;
         byte_idx      <= '0;
         shadow        <= '0;
         top_inputs    <= '0;
         left_inputs   <= '0;
         vector_valid  <= 1'b0;
         byte_out      <= '0;
         byte_valid    <= 1'b0;
         frame_err     <= 1'b0;
         vectors_count <= '0;
      end else begin
         vector_valid <= 1'b0;
         byte_valid   <= 1'b0;
         frame_err    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!rx_s) begin
                  state   <= S_START;
                  clk_cnt <= '0;
               end
            end
            S_START: begin
               // Mid-start-bit check rejects short glitches on the line.
               if (clk_cnt == CW'(H - 1)) begin
                  clk_cnt <= '0;
                  bit_idx <= '0;
                  state   <= rx_s ? S_IDLE : S_DATA;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                  clk_cnt <= '0;
                  shreg   <= {rx_s, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state <= S_STOP;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                  clk_cnt <= '0;
                  if (rx_s) begin
                     state      <= S_IDLE;
                     byte_out   <= shreg;
                     byte_valid <= 1'b1;
                     shadow[{byte_idx, 3'b000} +: 8] <= shreg;
                     if (byte_idx == 4'd11) begin
                        // Last byte goes straight to the output so both vectors update together.
                        top_inputs    <= shadow[31:0];
                        left_inputs   <= {shreg, shadow[87:32]};
                        vector_valid  <= 1'b1;
                        vectors_count <= vectors_count + 6'd1;
                        byte_idx      <= '0;
                     end else begin
                        byte_idx <= byte_idx + 4'd1;
                     end
                  end else begin
                     // Bad stop bit: drop the byte and the partial vector.
                     frame_err <= 1'b1;
                     byte_idx  <= '0;
                     state     <= S_BREAK;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            S_BREAK: begin
               // Wait out a held-low line so it raises only one frame error.
               if (rx_s) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_operand_loader.sv
// Directed bench for uart_operand_loader: single byte timing, full vector, glitch,
// bad stop bit, line break and mid-frame reset, with hand-computed expectations.
module tb_uart_operand_loader;

   localparam int CPB = 16;

   logic        clk;
   logic        rst;
   logic        rx;
   logic [31:0] top_inputs;
   logic [63:0] left_inputs;
   logic        vector_valid;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        frame_err;
   logic [5:0]  vectors_count;

   int n_checks = 0;
   int n_fail   = 0;

   int          cyc = 0;
   int          n_bv = 0;
   int          n_fe = 0;
   int          n_vv = 0;
   int          n_unstable = 0;
   int          bv_cyc = 0;
   logic        mon_en = 1'b0;
   logic [31:0] prev_top = '0;
   logic [63:0] prev_left = '0;

   uart_operand_loader #(.CLKS_PER_BIT(CPB)) dut (
      .clk           (clk),
      .rst           (rst),
      .rx            (rx),
      .top_inputs    (top_inputs),
      .left_inputs   (left_inputs),
      .vector_valid  (vector_valid),
      .byte_out      (byte_out),
      .byte_valid    (byte_valid),
      .frame_err     (frame_err),
      .vectors_count (vectors_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running cycle count for latency measurement.
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse counters and a check that vectors only move with vector_valid.
   always @(negedge clk) begin
      if (mon_en) begin
         if (byte_valid) begin
            n_bv   <= n_bv + 1;
            bv_cyc <= cyc;
         end
         if (frame_err)    n_fe <= n_fe + 1;
         if (vector_valid) n_vv <= n_vv + 1;
         if (!rst && !vector_valid && (top_inputs !== prev_top || left_inputs !== prev_left))
            n_unstable <= n_unstable + 1;
         prev_top  <= top_inputs;
         prev_left <= left_inputs;
      end
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called on a falling edge; holds one bit for a full bit time.
   task automatic drive_bit(input logic b);
      rx = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop_bit);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(stop_bit);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   int t0, bv0, fe0, vv0;

   initial begin
      rst = 1'b1;
      rx  = 1'b1;
      repeat (4) @(negedge clk);
      check_val("reset_top", 64'(top_inputs), 64'h0);
      check_val("reset_left", left_inputs, 64'h0);
      check_val("reset_byte_out", 64'(byte_out), 64'h0);
      check_val("reset_pulses", 64'({byte_valid, frame_err, vector_valid}), 64'h0);
      check_val("reset_count", 64'(vectors_count), 64'h0);
      rst = 1'b0;
      mon_en = 1'b1;
      idle(4);

      // Single byte with exact latency: pulse 155 posedges after the negedge rx falls.
      t0 = cyc;
      send_byte(8'hA5, 1'b1);
      idle(4);
      check_val("single_byte_out", 64'(byte_out), 64'hA5);
      check_val("single_bv_count", 64'(n_bv), 64'd1);
      check_val("single_bv_cycle", 64'(bv_cyc), 64'(t0 + 155));
      check_val("single_no_fe", 64'(n_fe), 64'd0);

      // Glitch: 3 low cycles must be rejected.
      rx = 1'b0;
      repeat (3) @(negedge clk);
      idle(40);
      check_val("glitch_no_bv", 64'(n_bv), 64'd1);
      check_val("glitch_no_fe", 64'(n_fe), 64'd0);

      // Glitch aside, 0xA5 sits at index 0; reset the index via a fresh reset of state.
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle(4);
      check_val("glitch_rst_count", 64'(vectors_count), 64'h0);

      // Full vector 0x01..0x0C back to back.
      bv0 = n_bv;
      vv0 = n_vv;
      for (int i = 1; i <= 11; i++) send_byte(8'(i), 1'b1);
      idle(2);
      check_val("vec_partial_top", 64'(top_inputs), 64'h0);
      check_val("vec_partial_vv", 64'(n_vv - vv0), 64'd0);
      send_byte(8'h0C, 1'b1);
      idle(4);
      check_val("vec_top", 64'(top_inputs), 64'h04030201);
      check_val("vec_left", left_inputs, 64'h0C0B0A0908070605);
      check_val("vec_vv", 64'(n_vv - vv0), 64'd1);
      check_val("vec_bv", 64'(n_bv - bv0), 64'd12);
      check_val("vec_count", 64'(vectors_count), 64'd1);
      check_val("vec_last_byte", 64'(byte_out), 64'h0C);

      // Bad stop bit mid-vector, then a clean vector 0x10..0x1B.
      fe0 = n_fe;
      vv0 = n_vv;
      for (int i = 0; i < 5; i++) send_byte(8'hE0 + 8'(i), 1'b1);
      send_byte(8'h77, 1'b0);
      idle(CPB);
      check_val("badstop_fe", 64'(n_fe - fe0), 64'd1);
      check_val("badstop_byte_out", 64'(byte_out), 64'hE4);
      check_val("badstop_top_kept", 64'(top_inputs), 64'h04030201);
      for (int i = 0; i < 12; i++) send_byte(8'h10 + 8'(i), 1'b1);
      idle(4);
      check_val("badstop_vv", 64'(n_vv - vv0), 64'd1);
      check_val("badstop_top", 64'(top_inputs), 64'h13121110);
      check_val("badstop_left", left_inputs, 64'h1B1A191817161514);
      check_val("badstop_count", 64'(vectors_count), 64'd2);
      check_val("badstop_fe_total", 64'(n_fe - fe0), 64'd1);

      // Line held low for 40 bit times, then byte 0x3C.
      fe0 = n_fe;
      bv0 = n_bv;
      rx = 1'b0;
      repeat (40 * CPB) @(negedge clk);
      idle(CPB);
      check_val("break_fe", 64'(n_fe - fe0), 64'd1);
      send_byte(8'h3C, 1'b1);
      idle(4);
      check_val("break_byte_out", 64'(byte_out), 64'h3C);
      check_val("break_bv", 64'(n_bv - bv0), 64'd1);
      check_val("break_fe_total", 64'(n_fe - fe0), 64'd1);

      // Reset during the data bits of the 7th byte.
      for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i), 1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      rst = 1'b1;
      rx  = 1'b1;
      @(negedge clk);
      check_val("midrst_top", 64'(top_inputs), 64'h0);
      check_val("midrst_left", left_inputs, 64'h0);
      check_val("midrst_byte_out", 64'(byte_out), 64'h0);
      check_val("midrst_count", 64'(vectors_count), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      idle(4 * CPB);
      bv0 = n_bv;
      vv0 = n_vv;
      check_val("midrst_no_pulse", 64'(bv_cyc < cyc - 3 * CPB), 64'd1);
      for (int i = 0; i < 12; i++) send_byte(8'h20 + 8'(i), 1'b1);
      idle(4);
      check_val("midrst_vec_count", 64'(vectors_count), 64'd1);
      check_val("midrst_vec_top", 64'(top_inputs), 64'h23222120);
      check_val("midrst_vec_left", left_inputs, 64'h2B2A292827262524);
      check_val("midrst_vv", 64'(n_vv - vv0), 64'd1);
      check_val("midrst_bv", 64'(n_bv - bv0), 64'd12);

      check_val("vector_stability", 64'(n_unstable), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
